calc_key_sequencer: RTL and testbench
=====================================

// Module: calc_key_sequencer
// PURPOSE
//  Upstream operand-entry stage of the calculator datapath. Accepts debounced keypad events,
//  collects operand A, the '+' operator and operand B, then presents both BCD digits to the
//  mod-10 digit adder. Captures the adder's result for the display stage.
//  Tracks entry progress with a small FSM and an inactivity timeout.
// PARAMETERS
//  TIMEOUT_CYC  default 50_000_000  idle cycles with no accepted key before auto-clear; 0 = disabled
//  CNT_W        default 26          timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  clk       in   1  single system clock; all state on rising edge
//  rst_n     in   1  asynchronous active-low reset; release is synchronised outside this block
//  key_stb   in   1  key-present level from debouncer; may stay high for many cycles
//  key_code  in   4  0-9 digit, 4'hA '+', 4'hB '=', 4'hC clear; 4'hD-4'hF invalid
//  add_res   in   4  BCD sum digit returned by the adder (combinational from dig1/dig2)
//  dig1      out  4  operand A to the adder
//  dig2      out  4  operand B to the adder
//  res_q     out  4  latched result digit for the display
//  res_vld   out  1  high while res_q holds a valid result
//  state_o   out  3  current FSM state encoding, for the display and debug
//  key_err   out  1  one-cycle pulse on an invalid or out-of-sequence key
// BEHAVIOUR
//  Reset: dig1=dig2=res_q=0, res_vld=0, key_err=0, state=S_IDLE, timeout counter=0, key_stb_q=0.
//  Key acceptance: a key is accepted only in the cycle where key_stb is high and key_stb_q is low
//   (rising edge; key_stb_q is key_stb delayed one cycle). Holding the key yields one event.
//  FSM transitions (each on an accepted key; any key not listed -> no state change, key_err pulse):
//   S_IDLE  digit d -> dig1<=d, S_OP1.
//   S_OP1   digit d -> dig1<=d (overwrite); '+' -> S_WAIT2.
//   S_WAIT2 digit d -> dig2<=d, S_OP2.
//   S_OP2   digit d -> dig2<=d (overwrite); '=' -> res_q<=add_res, res_vld<=1, S_RES.
//   S_RES   digit d -> dig1<=d, dig2<=0, res_vld<=0, S_OP1.
//  From S_RES, '+' behaviour depends on CONFIGURATION.
//  Clear key (4'hC), any state: dig1=dig2=0, res_vld=0, state=S_IDLE; key_err is not raised.
//  Invalid codes D-F: key_err pulse, no other change.
//  Latency: an accepted key updates dig1/dig2/state in the following cycle. res_q samples add_res
//   in the same edge as the '=' acceptance; dig1/dig2 are already stable at that edge.
//  Timeout: counter resets to 0 on every accepted key and in S_IDLE, otherwise increments by 1.
//   On reaching TIMEOUT_CYC, auto-clear to S_IDLE. S_RES is exempt: the result holds indefinitely.
//  Counter saturates and never wraps. A key accepted in the timeout cycle wins: key processed,
//   counter cleared.
//  Reset asserted mid-entry forces all outputs to their reset values immediately (asynchronous).
// CONFIGURATION
//  CALC_CHAIN_EN defined: in S_RES, '+' gives dig1<=res_q, dig2<=0, res_vld<=0, S_WAIT2
//   (chained accumulation).
//  CALC_CHAIN_EN undefined: in S_RES, '+' raises key_err with no state change.
// STRUCTURE
//  Shared package calc_pkg holds:
//   - key-code localparams: KEY_PLUS=4'hA, KEY_EQ=4'hB, KEY_CLR=4'hC
//   - state typedef: S_IDLE=0, S_OP1=1, S_WAIT2=2, S_OP2=3, S_RES=4
//   - function is_digit(code)
//  One sub-module, calc_idle_timer: counter, clear/enable inputs, expiry output.
//  FSM, operand registers and edge detect stay in this module.
// TESTING
//  1. Keys 3,+,4,= -> dig1=3, dig2=4; res_q=7, res_vld=1 one cycle after '='; state=S_RES.
//  2. Keys 9,+,8,= -> res_q=7 (mod-10 sum, no carry).
//  3. key_stb held high 20 cycles with code 5 in S_IDLE -> exactly one acceptance, dig1=5, S_OP1.
//  4. '=' in S_OP1 -> key_err single-cycle pulse, state stays S_OP1; code 4'hE -> key_err pulse.
//  5. TIMEOUT_CYC=10: key 2, then idle -> S_IDLE on cycle 10 with dig1=0; in S_RES no timeout.
//  6. With CALC_CHAIN_EN: 3,+,4,=,+,5,= -> res_q=2; without it, the second '+' gives key_err
//     and res_q stays 7.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encoding and key classification for the calculator entry path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    // Non-digit key codes from the keypad debouncer; 4'hD-4'hF are unassigned.
    localparam logic [3:0] KEY_PLUS = 4'hA;
    localparam logic [3:0] KEY_EQ   = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;

    // Entry progress; the encoding is exported on state_o for display and debug.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OP1   = 3'd1,
        S_WAIT2 = 3'd2,
        S_OP2   = 3'd3,
        S_RES   = 3'd4
    } state_t;

    // True for the decimal digit keys 0-9.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/calc_idle_timer.sv
// Inactivity counter: clears on clr, otherwise counts up and saturates; flags expiry at TIMEOUT_CYC.
// Latency: expired is combinational from the count and is high in the cycle whose edge reaches TIMEOUT_CYC.
// Backpressure: none; clr always wins over expiry, and TIMEOUT_CYC=0 never expires.
module calc_idle_timer #(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // The count that, once incremented, equals TIMEOUT_CYC.
    localparam logic [CNT_W-1:0] LAST_CNT = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] MAX_CNT  = '1;
    localparam logic             TO_ON    = (TIMEOUT_CYC > 0);

    logic [CNT_W-1:0] cnt;

    // Idle counter: cleared on request, otherwise counts and sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != MAX_CNT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = TO_ON && en && !clr && (cnt == LAST_CNT);

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad operand sequencer: collects A '+' B '=' into BCD operands and latches the adder's sum.
// Latency: accepted key updates dig1/dig2/state/res_q next edge; key_err is a registered 1-cycle pulse.
// Backpressure: none; one event per key_stb rising edge. CALC_CHAIN_EN enables '+' chaining from S_RES.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_stb,
    input  logic [3:0] key_code,
    input  logic [3:0] add_res,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] res_q,
    output logic       res_vld,
    output logic [2:0] state_o,
    output logic       key_err
);

    state_t     state, state_nxt;
    logic [3:0] dig1_nxt, dig2_nxt, res_q_nxt;
    logic       res_vld_nxt, key_err_nxt;
    logic       key_stb_q;
    logic       key_acc;
    logic       to_clr, to_en, to_expired;

    // The debouncer holds key_stb for the whole press; only its rising edge is an event.
    assign key_acc = key_stb && !key_stb_q;

    // Idle time only matters mid-entry; a shown result is held indefinitely.
    assign to_clr = key_acc || (state == S_IDLE);
    assign to_en  = (state != S_RES);

    calc_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // Key strobe history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_stb_q <= 1'b0;
        end else begin
            key_stb_q <= key_stb;
        end
    end

    // State, operand, result and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            dig1    <= 4'd0;
            dig2    <= 4'd0;
            res_q   <= 4'd0;
            res_vld <= 1'b0;
            key_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            dig1    <= dig1_nxt;
            dig2    <= dig2_nxt;
            res_q   <= res_q_nxt;
            res_vld <= res_vld_nxt;
            key_err <= key_err_nxt;
        end
    end

    // Next-state decode: an accepted key takes priority over an expiring idle timer.
    always_comb begin
        state_nxt   = state;
        dig1_nxt    = dig1;
        dig2_nxt    = dig2;
        res_q_nxt   = res_q;
        res_vld_nxt = res_vld;
        key_err_nxt = 1'b0;

        if (key_acc) begin
            if (is_digit(key_code)) begin
                case (state)
                    S_IDLE, S_OP1: begin
                        dig1_nxt  = key_code;
                        state_nxt = S_OP1;
                    end
                    S_WAIT2, S_OP2: begin
                        dig2_nxt  = key_code;
                        state_nxt = S_OP2;
                    end
                    S_RES: begin
                        // A digit after a result starts a fresh calculation.
                        dig1_nxt    = key_code;
                        dig2_nxt    = 4'd0;
                        res_vld_nxt = 1'b0;
                        state_nxt   = S_OP1;
                    end
                    default: begin
                        key_err_nxt = 1'b1;
                    end
                endcase
            end else if (key_code == KEY_CLR) begin
                dig1_nxt    = 4'd0;
                dig2_nxt    = 4'd0;
                res_vld_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end else if (key_code == KEY_PLUS) begin
                if (state == S_OP1) begin
                    state_nxt = S_WAIT2;
                end else if (state == S_RES) begin
`ifdef CALC_CHAIN_EN
                    // Chained accumulation: the shown result becomes operand A.
                    dig1_nxt    = res_q;
                    dig2_nxt    = 4'd0;
                    res_vld_nxt = 1'b0;
                    state_nxt   = S_WAIT2;
`else
                    key_err_nxt = 1'b1;
`endif
                end else begin
                    key_err_nxt = 1'b1;
                end
            end else if (key_code == KEY_EQ) begin
                if (state == S_OP2) begin
                    // dig1/dig2 have been stable since the previous edge, so add_res is settled.
                    res_q_nxt   = add_res;
                    res_vld_nxt = 1'b1;
                    state_nxt   = S_RES;
                end else begin
                    key_err_nxt = 1'b1;
                end
            end else begin
                key_err_nxt = 1'b1;
            end
        end else if (to_expired) begin
            // Abandoned entry: behave as if clear had been pressed.
            dig1_nxt    = 4'd0;
            dig2_nxt    = 4'd0;
            res_vld_nxt = 1'b0;
            state_nxt   = S_IDLE;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;
    import calc_pkg::*;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_stb;
    logic [3:0] key_code;
    logic [3:0] add_res;
    logic [3:0] dig1, dig2, res_q;
    logic       res_vld;
    logic [2:0] state_o;
    logic       key_err;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_on  = 1'b0;

    calc_key_sequencer #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_stb  (key_stb),
        .key_code (key_code),
        .add_res  (add_res),
        .dig1     (dig1),
        .dig2     (dig2),
        .res_q    (res_q),
        .res_vld  (res_vld),
        .state_o  (state_o),
        .key_err  (key_err)
    );

    always #5 clk = ~clk;

    // Mod-10 digit adder feeding the DUT.
    always_comb add_res = 4'((int'(dig1) + int'(dig2)) % 10);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: entry phase plus operands, advanced once per clock.
    int  m_ph, m_d1, m_d2, m_rq, m_idle;
    bit  m_vld, m_err, m_prev;

    task automatic m_clear();
        m_d1 = 0; m_d2 = 0; m_vld = 0; m_ph = 0;
    endtask

    task automatic m_key(input int k);
        if (k <= 9) begin
            if (m_ph == 0 || m_ph == 1) begin m_d1 = k; m_ph = 1; end
            else if (m_ph == 2 || m_ph == 3) begin m_d2 = k; m_ph = 3; end
            else begin m_d1 = k; m_d2 = 0; m_vld = 0; m_ph = 1; end
        end else if (k == 12) begin
            m_clear();
        end else if (k == 10 && m_ph == 1) begin
            m_ph = 2;
        end else if (k == 10 && m_ph == 4) begin
`ifdef CALC_CHAIN_EN
            m_d1 = m_rq; m_d2 = 0; m_vld = 0; m_ph = 2;
`else
            m_err = 1;
`endif
        end else if (k == 11 && m_ph == 3) begin
            m_rq = (m_d1 + m_d2) % 10; m_vld = 1; m_ph = 4;
        end else begin
            m_err = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear(); m_rq = 0; m_idle = 0; m_err = 0; m_prev = 0;
        end else begin
            bit acc;
            acc = key_stb && !m_prev;
            m_prev = key_stb;
            m_err = 0;
            if (acc) begin
                m_key(int'(key_code));
                m_idle = 0;
            end else if (m_ph == 0) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TO && m_ph != 4) m_clear();
            end
        end
    end

    // Every cycle, compare the DUT against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_state", 8'(state_o), 8'(m_ph));
            chk("m_dig1",  8'(dig1),    8'(m_d1));
            chk("m_dig2",  8'(dig2),    8'(m_d2));
            chk("m_res_q", 8'(res_q),   8'(m_rq));
            chk("m_vld",   8'(res_vld), 8'(m_vld));
            chk("m_err",   8'(key_err), 8'(m_err));
        end
    end

    task automatic press(input logic [3:0] code, input int hold, input int gap);
        @(posedge clk);
        #1 key_code = code; key_stb = 1'b1;
        repeat (hold) @(posedge clk);
        #1 key_stb = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic seq_3p4e();
        press(KEY_CLR, 1, 1);
        press(4'd3, 1, 1);
        press(KEY_PLUS, 1, 1);
        press(4'd4, 1, 1);
        press(KEY_EQ, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0; key_stb = 1'b0; key_code = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 8'(state_o), 8'(S_IDLE));
        chk("rst_dig1",  8'(dig1), 8'd0);
        chk("rst_res_q", 8'(res_q), 8'd0);
        chk("rst_vld",   8'(res_vld), 8'd0);
        chk("rst_err",   8'(key_err), 8'd0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // 3 + 4 =
        seq_3p4e();
        #1;
        chk("t1_dig1", 8'(dig1), 8'd3);
        chk("t1_dig2", 8'(dig2), 8'd4);
        chk("t1_res",  8'(res_q), 8'd7);
        chk("t1_vld",  8'(res_vld), 8'd1);
        chk("t1_st",   8'(state_o), 8'(S_RES));

        // 9 + 8 = wraps mod 10
        press(KEY_CLR, 1, 1);
        press(4'd9, 1, 1);
        press(KEY_PLUS, 1, 1);
        press(4'd8, 1, 1);
        press(KEY_EQ, 1, 0);
        #1 chk("t2_res", 8'(res_q), 8'd7);

        // Long hold: one acceptance, then the idle timer fires while still held
        press(KEY_CLR, 1, 1);
        @(posedge clk);
        #1 key_code = 4'd5; key_stb = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t3_dig1", 8'(dig1), 8'd5);
        chk("t3_st",   8'(state_o), 8'(S_OP1));
        repeat (15) @(posedge clk);
        #1;
        chk("t3_st_end", 8'(state_o), 8'(S_IDLE));
        chk("t3_dig1_end", 8'(dig1), 8'd0);
        key_stb = 1'b0;
        repeat (2) @(posedge clk);

        // Out-of-sequence and invalid keys
        press(4'd1, 1, 1);
        press(KEY_EQ, 1, 0);
        #1;
        chk("t4_err", 8'(key_err), 8'd1);
        chk("t4_st",  8'(state_o), 8'(S_OP1));
        @(posedge clk);
        #1 chk("t4_err_end", 8'(key_err), 8'd0);
        press(4'hE, 1, 0);
        #1 chk("t4_inv_err", 8'(key_err), 8'd1);

        // Timeout after exactly TO idle cycles
        press(KEY_CLR, 1, 1);
        press(4'd2, 1, 0);
        repeat (TO - 1) @(posedge clk);
        #1 chk("t5_pre", 8'(state_o), 8'(S_OP1));
        @(posedge clk);
        #1;
        chk("t5_st",   8'(state_o), 8'(S_IDLE));
        chk("t5_dig1", 8'(dig1), 8'd0);
        seq_3p4e();
        repeat (3 * TO) @(posedge clk);
        #1;
        chk("t5_res_st",  8'(state_o), 8'(S_RES));
        chk("t5_res_vld", 8'(res_vld), 8'd1);

        // Chaining from a shown result
        seq_3p4e();
        press(KEY_PLUS, 1, 0);
        #1;
`ifdef CALC_CHAIN_EN
        chk("t6_plus_st", 8'(state_o), 8'(S_WAIT2));
`else
        chk("t6_plus_err", 8'(key_err), 8'd1);
`endif
        press(4'd5, 1, 1);
        press(KEY_EQ, 1, 0);
        #1;
`ifdef CALC_CHAIN_EN
        chk("t6_res", 8'(res_q), 8'd2);
`else
        chk("t6_res", 8'(res_q), 8'd7);
`endif

        // Randomised key streams with occasional asynchronous reset mid-entry
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [3:0] c;
            r = $urandom_range(0, 9);
            if (r <= 3)      c = 4'($urandom_range(0, 9));
            else if (r <= 5) c = KEY_PLUS;
            else if (r <= 7) c = KEY_EQ;
            else if (r == 8) c = KEY_CLR;
            else             c = 4'($urandom_range(0, 15));
            press(c, $urandom_range(1, 3), $urandom_range(0, 13));
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("ar_state", 8'(state_o), 8'(S_IDLE));
                chk("ar_dig1",  8'(dig1), 8'd0);
                chk("ar_dig2",  8'(dig2), 8'd0);
                chk("ar_res_q", 8'(res_q), 8'd0);
                chk("ar_vld",   8'(res_vld), 8'd0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        repeat (2) @(posedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
